program_loader: RTL

Boot-time loader upstream of instruction memory and the SM core. Accepts a byte stream from a host link over a valid/ready handshake, assembles little-endian instruction words, writes them to consecutive instruction-memory addresses from 0, and holds the SM core in reset until the program image is complete. Once loading finishes it releases the core, which begins fetching at address 0.

---
 rtl/program_loader.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/program_loader.sv
// program_loader: boot-time loader. Assembles little-endian instruction words
// from a host byte stream, writes them to instruction memory from address 0,
// and holds the SM core in reset until the image is complete.
// Optional feature macro: LOADER_CHECKSUM_EN (trailing XOR checksum byte).
module program_loader #(
    parameter int unsigned INST_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [7:0]            in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  reload,
    output logic                  im_wr_en,
    output logic [ADDR_WIDTH-1:0] im_wr_addr,
    output logic [INST_WIDTH-1:0] im_wr_data,
    output logic                  core_reset,
    output logic                  done,
    output logic                  error
);

    localparam int unsigned BPW = INST_WIDTH / 8;
    localparam int unsigned BCW = (BPW > 1) ? $clog2(BPW) : 1;
    localparam int unsigned CW  = 16;

    typedef enum logic [2:0] {
        S_HDR_LO = 3'd0,
        S_HDR_HI = 3'd1,
        S_DATA   = 3'd2,
        S_CSUM   = 3'd3,
        S_DONE   = 3'd4,
        S_ERROR  = 3'd5
    } state_t;

`ifdef LOADER_CHECKSUM_EN
    localparam state_t S_AFTER_DATA = S_CSUM;
`else
    localparam state_t S_AFTER_DATA = S_DONE;
`endif

    state_t                  state;
    state_t                  state_next;
    logic [CW-1:0]           count;
    logic [CW-1:0]           word_cnt;
    logic [BCW-1:0]          byte_cnt;
    logic [ADDR_WIDTH-1:0]   addr;
    logic [INST_WIDTH-1:0]   word;
    logic [INST_WIDTH-1:0]   word_next;
    logic                    accept;
    logic                    take_reload;
    logic                    last_byte;
    logic                    last_word;
    logic                    hdr_zero;
    logic                    done_hold;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]              csum;
`endif

    assign accept      = in_valid && in_ready;
    assign take_reload = reload && ((state == S_DONE) || (state == S_ERROR));
    assign last_byte   = (byte_cnt == BCW'(BPW - 1));
    assign last_word   = (word_cnt == (count - CW'(1)));
    assign hdr_zero    = (in_data == 8'd0) && (count[7:0] == 8'd0);
    assign done_hold   = (state == S_DONE) && !take_reload;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_HDR_LO;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode
    always_comb begin
        state_next = state;
        case (state)
            S_HDR_LO: if (accept) state_next = S_HDR_HI;
            S_HDR_HI: if (accept) state_next = hdr_zero ? S_AFTER_DATA : S_DATA;
            S_DATA:   if (accept && last_byte && last_word) state_next = S_AFTER_DATA;
`ifdef LOADER_CHECKSUM_EN
            S_CSUM:   if (accept) state_next = (in_data == csum) ? S_DONE : S_ERROR;
            S_ERROR:  if (take_reload) state_next = S_HDR_LO;
`endif
            S_DONE:   if (take_reload) state_next = S_HDR_LO;
            default:  state_next = S_HDR_LO;
        endcase
    end

    // Insert the incoming byte into its lane of the word being assembled
    always_comb begin
        word_next = word;
        for (int unsigned b = 0; b < BPW; b++) begin
            if (byte_cnt == BCW'(b)) begin
                word_next[b*8 +: 8] = in_data;
            end
        end
    end

    // Header capture, word assembly, memory write and status outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            in_ready   <= 1'b1;
            im_wr_en   <= 1'b0;
            im_wr_addr <= '0;
            im_wr_data <= '0;
            core_reset <= 1'b1;
            done       <= 1'b0;
            count      <= '0;
            word_cnt   <= '0;
            byte_cnt   <= '0;
            addr       <= '0;
            word       <= '0;
        end else begin
            im_wr_en   <= 1'b0;
            in_ready   <= (state_next != S_DONE) && (state_next != S_ERROR);
            done       <= done_hold;
            core_reset <= !done_hold;
            if (take_reload) begin
                count    <= '0;
                word_cnt <= '0;
                byte_cnt <= '0;
                addr     <= '0;
            end
            if (accept) begin
                case (state)
                    S_HDR_LO: count[7:0]    <= in_data;
                    S_HDR_HI: count[CW-1:8] <= in_data;
                    S_DATA: begin
                        word <= word_next;
                        if (last_byte) begin
                            byte_cnt   <= '0;
                            im_wr_en   <= 1'b1;
                            im_wr_addr <= addr;
                            im_wr_data <= word_next;
                            addr       <= addr + ADDR_WIDTH'(1);
                            word_cnt   <= word_cnt + CW'(1);
                        end else begin
                            byte_cnt <= byte_cnt + BCW'(1);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

`ifdef LOADER_CHECKSUM_EN
    // Running XOR of data bytes and the registered error flag
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            csum  <= 8'd0;
            error <= 1'b0;
        end else begin
            error <= (state == S_ERROR) && !take_reload;
            if (take_reload) begin
                csum <= 8'd0;
            end else if (accept && (state == S_DATA)) begin
                csum <= csum ^ in_data;
            end
        end
    end
`else
    assign error = 1'b0;
`endif

endmodule
